// File: rtl/spmv_read_arbiter_pkg.sv
// Shared types and constants for the spmv read-issue arbiter.
package spmv_arb_pkg;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} arb_state_e;

  localparam int SERVE_W_DEF = 3;
  localparam int SEQ_W_DEF   = 3;
  localparam logic [7:0] AR_LEN = 8'd0;
endpackage

// File: rtl/spmv_read_arbiter_if.sv
// AR channel plus the serve/sequence tags handed to the issue unit.
interface spmv_read_arbiter_if
  import spmv_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SERVE_W    = SERVE_W_DEF,
  parameter int SEQ_W      = SEQ_W_DEF
) ();
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [SERVE_W-1:0]    Req_Fifo_ServeNum;
  logic [SEQ_W-1:0]      Req_Seq;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arvalid, Req_Fifo_ServeNum, Req_Seq,
    input  m_axi_arready
  );
  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arvalid, Req_Fifo_ServeNum, Req_Seq,
    output m_axi_arready
  );
endinterface

// File: rtl/spmv_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping mod N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);
  logic [2*N-1:0] w_rot;
  int             w_sum;

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    w_sum   = 0;
    // Rotate so offset 0 is the pointer; scan downward so the nearest offset wins.
    w_rot   = {i_req, i_req} >> i_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = int'(i_ptr) + k;
        if (w_sum >= N) w_sum = w_sum - N;
        o_idx = IDX_W'(w_sum);
      end
    end
  end
endmodule

// File: rtl/spmv_read_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI AR path among NUM_REQ requester FIFOs.
module spmv_read_arbiter
  import spmv_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int SERVE_W    = SERVE_W_DEF,
  parameter int SEQ_W      = SEQ_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_empty,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_rd,
  input  logic                          Issue_BUSY,
  input  logic                          Fifo_Post_full,
  spmv_read_arbiter_if.master           ar,
  output logic                          arb_busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e                            r_state;
  logic [IDX_W-1:0]                      r_ptr;
  logic [IDX_W-1:0]                      r_win;
  logic [NUM_REQ-1:0][SEQ_W-1:0]         r_seq;
  logic [NUM_REQ-1:0]                    r_rd;
  logic [ADDR_WIDTH-1:0]                 r_araddr;
  logic [SEQ_W-1:0]                      r_tag;
  logic                                  r_arvalid;
  logic                                  r_busy;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    w_addr;
  logic                                  w_any;
  logic [IDX_W-1:0]                      w_win;
  logic                                  w_elig;

  assign w_addr = req_addr;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req   (~req_empty),
    .i_ptr   (r_ptr),
    .o_valid (w_any),
    .o_idx   (w_win)
  );

  assign w_elig = arb_en & ~Issue_BUSY & ~Fifo_Post_full & w_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_seq     <= '0;
      r_rd      <= '0;
      r_araddr  <= '0;
      r_tag     <= '0;
      r_arvalid <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rd <= '0;
      case (r_state)
        IDLE: begin
          if (w_elig) begin
            r_rd      <= NUM_REQ'(1) << w_win;
            r_araddr  <= w_addr[w_win];
            r_win     <= w_win;
            r_tag     <= r_seq[w_win];
            r_arvalid <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          // Entry is already popped, so the grant completes whatever the gating inputs do.
          if (ar.m_axi_arready) begin
            r_seq[r_win] <= r_seq[r_win] + SEQ_W'(1);
            r_ptr        <= (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + IDX_W'(1);
            r_arvalid    <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_rd               = r_rd;
  assign arb_busy             = r_busy;
  assign ar.m_axi_araddr      = r_araddr;
  assign ar.m_axi_arlen       = AR_LEN;
  assign ar.m_axi_arvalid     = r_arvalid;
  assign ar.Req_Fifo_ServeNum = SERVE_W'(r_win);
  assign ar.Req_Seq           = r_tag;
endmodule

// File: tb/tb_spmv_read_arbiter.sv
// Scoreboard bench for spmv_read_arbiter: FIFO model, expected-AR queue, gating vector table.
module tb_spmv_read_arbiter;
  localparam int NR = 4;
  localparam int AW = 64;

  typedef struct {
    logic [2:0]  serve;
    logic [63:0] addr;
    logic [2:0]  seq;
  } exp_t;

  typedef struct {
    logic       en;
    logic       busy;
    logic       pf;
    logic [3:0] mask;
    logic [3:0] exp_rd;
    logic [2:0] serve;
    logic [2:0] seq;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arb_en = 1'b0;
  logic [NR-1:0]     req_empty = '1;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR-1:0]     req_rd;
  logic              Issue_BUSY = 1'b0;
  logic              Fifo_Post_full = 1'b0;
  logic              arb_busy;

  spmv_read_arbiter_if #(.ADDR_WIDTH(AW), .SERVE_W(3), .SEQ_W(3)) ar_if ();

  spmv_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .SERVE_W(3), .SEQ_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .arb_en         (arb_en),
    .req_empty      (req_empty),
    .req_addr       (req_addr),
    .req_rd         (req_rd),
    .Issue_BUSY     (Issue_BUSY),
    .Fifo_Post_full (Fifo_Post_full),
    .ar             (ar_if.master),
    .arb_busy       (arb_busy)
  );

  always #5 clk = ~clk;

  logic [63:0] fq [NR][$];
  exp_t        sb [$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_pop = 0;
  int          n_hs  = 0;
  vec_t        vt [10];

  function automatic logic [63:0] mk(int t, int k, int i);
    return (64'(t + 1) << 48) | (64'(k) << 8) | 64'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      req_empty[i] = (fq[i].size() == 0);
      req_addr[i*AW +: AW] = (fq[i].size() > 0) ? fq[i][0] : 64'h0;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) fq[i].delete();
    refresh();
  endtask

  // Inputs set before tick() are what the coming posedge sees; a handshake
  // visible now completes at that edge.
  task automatic tick();
    exp_t e;
    if (ar_if.m_axi_arvalid && ar_if.m_axi_arready) begin
      n_hs++;
      chk("ar_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ar_serve", 64'(ar_if.Req_Fifo_ServeNum), 64'(e.serve));
        chk("ar_addr", ar_if.m_axi_araddr, e.addr);
        chk("ar_seq", 64'(ar_if.Req_Seq), 64'(e.seq));
        chk("ar_len", 64'(ar_if.m_axi_arlen), 64'd0);
      end
    end
    @(negedge clk);
    if (req_rd != '0) begin
      chk("rd_onehot", 64'($onehot(req_rd)), 64'd1);
      for (int i = 0; i < NR; i++) begin
        if (req_rd[i]) begin
          n_pop++;
          if (fq[i].size() > 0) void'(fq[i].pop_front());
          else chk("pop_nonempty", 64'd0, 64'd1);
        end
      end
    end
    refresh();
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && (sb.size() > 0 || ar_if.m_axi_arvalid); c++) tick();
    chk("drain_done", 64'(sb.size()), 64'd0);
    chk("pops_eq_handshakes", 64'(n_pop), 64'(n_hs));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    clear_all();
    sb.delete();
    n_pop = 0;
    n_hs  = 0;
    rst = 1'b0;
  endtask

  initial begin
    ar_if.m_axi_arready = 1'b0;
    vt[0] = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 3'd0, 3'd0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 3'd0, 3'd0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 4'b1111, 4'b0000, 3'd0, 3'd0};
    vt[3] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 3'd0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 4'b1011, 4'b1000, 3'd3, 3'd0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 4'b0110, 4'b0010, 3'd1, 3'd2};
    vt[6] = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 3'd0, 3'd0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'b0010, 3'd1, 3'd3};
    vt[8] = '{1'b1, 1'b0, 1'b0, 4'b1001, 4'b1000, 3'd3, 3'd1};
    vt[9] = '{1'b1, 1'b0, 1'b0, 4'b1100, 4'b0100, 3'd2, 3'd2};

    // Reset values
    tick();
    chk("rst_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    chk("rst_rd", 64'(req_rd), 64'd0);
    chk("rst_araddr", ar_if.m_axi_araddr, 64'd0);
    chk("rst_serve", 64'(ar_if.Req_Fifo_ServeNum), 64'd0);
    chk("rst_seq", 64'(ar_if.Req_Seq), 64'd0);
    chk("rst_busy", 64'(arb_busy), 64'd0);
    do_reset();

    // All four requesters pending: 0,1,2,3 then 0 again
    for (int i = 0; i < NR; i++) fq[i].push_back(mk(0, 0, i));
    fq[0].push_back(mk(0, 1, 0));
    refresh();
    for (int i = 0; i < NR; i++) sb.push_back('{3'(i), mk(0, 0, i), 3'd0});
    sb.push_back('{3'd0, mk(0, 1, 0), 3'd1});
    arb_en = 1'b1;
    ar_if.m_axi_arready = 1'b1;
    drain(60);

    // Single requester 2, ten entries: seq wraps 7 -> 0
    do_reset();
    for (int k = 0; k < 10; k++) begin
      fq[2].push_back(mk(1, k, 2));
      sb.push_back('{3'd2, mk(1, k, 2), 3'(k % 8)});
    end
    refresh();
    drain(80);

    // Requester 1 stalled on arready for 5 cycles; gating inputs wiggle meanwhile
    fq[1].push_back(mk(2, 0, 1));
    fq[1].push_back(mk(2, 1, 1));
    refresh();
    sb.push_back('{3'd1, mk(2, 0, 1), 3'd0});
    sb.push_back('{3'd1, mk(2, 1, 1), 3'd1});
    ar_if.m_axi_arready = 1'b0;
    tick();
    chk("stall_grant_rd", 64'(req_rd), 64'b0010);
    for (int c = 0; c < 5; c++) begin
      arb_en = c[0];
      Issue_BUSY = c[1];
      Fifo_Post_full = ~c[0];
      tick();
      chk("stall_arvalid", 64'(ar_if.m_axi_arvalid), 64'd1);
      chk("stall_addr", ar_if.m_axi_araddr, mk(2, 0, 1));
      chk("stall_serve", 64'(ar_if.Req_Fifo_ServeNum), 64'd1);
      chk("stall_seq", 64'(ar_if.Req_Seq), 64'd0);
      chk("stall_no_rd", 64'(req_rd), 64'd0);
    end
    arb_en = 1'b1;
    Issue_BUSY = 1'b0;
    Fifo_Post_full = 1'b0;
    ar_if.m_axi_arready = 1'b1;
    drain(40);

    // Gating / round-robin vector table
    for (int v = 0; v < 10; v++) begin
      ar_if.m_axi_arready = 1'b0;
      arb_en = vt[v].en;
      Issue_BUSY = vt[v].busy;
      Fifo_Post_full = vt[v].pf;
      for (int i = 0; i < NR; i++) if (vt[v].mask[i]) fq[i].push_back(mk(3, v, i));
      refresh();
      tick();
      chk($sformatf("vec%0d_rd", v), 64'(req_rd), 64'(vt[v].exp_rd));
      chk($sformatf("vec%0d_busy", v), 64'(arb_busy), 64'(|vt[v].exp_rd));
      if (vt[v].exp_rd != 4'b0000) begin
        chk($sformatf("vec%0d_serve", v), 64'(ar_if.Req_Fifo_ServeNum), 64'(vt[v].serve));
        chk($sformatf("vec%0d_seq", v), 64'(ar_if.Req_Seq), 64'(vt[v].seq));
        chk($sformatf("vec%0d_addr", v), ar_if.m_axi_araddr, mk(3, v, int'(vt[v].serve)));
        sb.push_back('{vt[v].serve, mk(3, v, int'(vt[v].serve)), vt[v].seq});
      end
      arb_en = 1'b0;
      ar_if.m_axi_arready = 1'b1;
      tick();
      tick();
      chk($sformatf("vec%0d_idle", v), 64'(arb_busy), 64'd0);
      clear_all();
    end
    Issue_BUSY = 1'b0;
    Fifo_Post_full = 1'b0;

    // Issue_BUSY holds off a pending request; grant follows its release by one cycle
    arb_en = 1'b1;
    Issue_BUSY = 1'b1;
    fq[0].push_back(mk(4, 0, 0));
    refresh();
    sb.push_back('{3'd0, mk(4, 0, 0), 3'd1});
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("busy_hold_rd", 64'(req_rd), 64'd0);
      chk("busy_hold_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    end
    Issue_BUSY = 1'b0;
    tick();
    chk("busy_release_rd", 64'(req_rd), 64'b0001);
    drain(20);

    // Asynchronous reset while an AR is waiting on arready
    ar_if.m_axi_arready = 1'b0;
    fq[3].push_back(mk(5, 0, 3));
    refresh();
    tick();
    chk("pre_rst_arvalid", 64'(ar_if.m_axi_arvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_arvalid", 64'(ar_if.m_axi_arvalid), 64'd0);
    chk("async_rst_busy", 64'(arb_busy), 64'd0);
    tick();
    clear_all();
    sb.delete();
    n_pop = 0;
    n_hs = 0;
    rst = 1'b0;
    fq[0].push_back(mk(6, 0, 0));
    fq[2].push_back(mk(6, 0, 2));
    refresh();
    sb.push_back('{3'd0, mk(6, 0, 0), 3'd0});
    sb.push_back('{3'd2, mk(6, 0, 2), 3'd0});
    ar_if.m_axi_arready = 1'b1;
    drain(30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/spmv_read_arbiter.md
Name: spmv_read_arbiter

Overview:
- Round-robin scheduler that shares the spmv kernel's single AXI read-issue path between up to 8 requester queues, such as column-index, value and x-vector fetchers.
- Pops one address from the winning requester and drives a single-beat AR transaction.
- Presents the winner's serve number and a per-requester 3-bit sequence tag to the issue unit, which tags the returned beat.
- Sits between the requester FIFOs and the issue unit / m_axi AR channel; honours the issue unit's busy and post-FIFO-full status.

Parameters:
- NUM_REQ, 4, number of requester queues (1..8).
- ADDR_WIDTH, 64, AXI read address width.
- SERVE_W, 3, serve-number width; must satisfy 2**SERVE_W >= NUM_REQ.
- SEQ_W, 3, per-requester sequence tag width.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- arb_en  in  1  global enable; when 0, no new grant starts.
- req_empty  in  NUM_REQ  per-requester FIFO empty flag (FWFT FIFOs).
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester head address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_rd  out  NUM_REQ  one-hot pop pulse.
- Issue_BUSY  in  1  issue unit cannot accept a new AR.
- Fifo_Post_full  in  1  issue unit's post FIFO is full.
- m_axi_araddr  out  ADDR_WIDTH  read address.
- m_axi_arlen  out  8  constant 0 (single beat).
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- Req_Fifo_ServeNum  out  SERVE_W  index of the granted requester.
- Req_Seq  out  SEQ_W  sequence tag of the granted request.
- arb_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - m_axi_arvalid=0, req_rd=0, m_axi_araddr=0, Req_Fifo_ServeNum=0, Req_Seq=0, arb_busy=0.
  - RR pointer=0; all sequence counters=0.
- FSM states: IDLE, ISSUE.
- IDLE:
  - Eligible when arb_en & ~Issue_BUSY & ~Fifo_Post_full & (|~req_empty).
  - When eligible, pick the winner w: the first non-empty requester at or after the RR pointer, searching upward with wrap modulo NUM_REQ.
  - In the same cycle: pulse req_rd[w]=1 for exactly 1 cycle, register req_addr[w] into m_axi_araddr, register w into Req_Fifo_ServeNum, register seq[w] into Req_Seq, and move to ISSUE.
  - When not eligible: stay in IDLE, all pops 0.
- ISSUE:
  - m_axi_arvalid=1; araddr, ServeNum and Seq are held stable until arready.
  - On m_axi_arvalid & m_axi_arready: seq[w] <= seq[w]+1 (wraps 7->0), RR pointer <= (w+1) mod NUM_REQ, arvalid drops next cycle, return to IDLE.
  - arb_en, Issue_BUSY and Fifo_Post_full are ignored in ISSUE; an accepted grant always completes.
- Latency:
  - Grant cycle to arvalid high: 1 cycle.
  - Minimum spacing between AR handshakes: 2 cycles, further throttled by Issue_BUSY (its cooldown and 2-outstanding limit).
- Edge cases:
  - Single non-empty requester: it wins every eligible cycle regardless of the pointer.
  - NUM_REQ=1: pointer stays 0.
  - Requester goes empty after winning: no effect, because the entry is already popped.
  - Unused serve codes >= NUM_REQ are never driven.
  - RR pointer arithmetic wraps modulo NUM_REQ, not 2**SERVE_W.
- Reset mid-ISSUE: the in-flight popped address is discarded. Requester FIFOs and the issue unit share the same reset, so no tag mismatch results.
- No combinational path from m_axi_arready to m_axi_arvalid or req_rd.

Decomposition:
- Package spmv_arb_pkg holds:
  - FSM state enum {IDLE, ISSUE}.
  - SERVE_W and SEQ_W defaults.
  - AXI arlen constant 8'd0.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: valid, winner index.
  - Reused by other kernel arbiters.

Test Plan:
- Reset, then all 4 requesters non-empty, arready=1, Issue_BUSY=0 -> AR ServeNum sequence is 0,1,2,3,0; araddr matches each FIFO head; each req_rd pulses exactly once per grant.
- Only requester 2 non-empty with 10 entries -> ServeNum=2 on every AR; Req_Seq runs 0..7, then 0,1 (wrap).
- Requester 1 wins while arready is held low 5 cycles -> arvalid stays high 5 cycles with araddr, ServeNum=1 and Seq stable; req_rd[1] pulses once only; next grant comes after the handshake.
- Issue_BUSY=1 or Fifo_Post_full=1 while requests are pending -> no req_rd and no arvalid; first grant appears 1 cycle after the input deasserts.
- arb_en=0 with pending requests -> stays IDLE; setting arb_en=1 mid-ISSUE wait has no effect on the in-flight AR.
- rst asserted asynchronously in ISSUE (mid-cycle) -> arvalid drops immediately; after release, seq counters=0 and the RR pointer restarts at requester 0.
